// File: rtl/overlap_param_pkg.sv
// rtl/overlap_param_pkg.sv - shared types and elaboration helpers for overlap_param.
package overlap_param_pkg;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_FILL,
    ST_EMIT,
    ST_REFILL
  } state_t;

  // Counter width for a range of n values; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic bit params_legal(input int channels, input int frame_len, input int hop);
    return (channels >= 1) && (hop >= 1) && (hop <= frame_len);
  endfunction

endpackage

// File: rtl/overlap_param_if.sv
// rtl/overlap_param_if.sv - PCM input and frame output handshakes of overlap_param.
interface overlap_param_if
  import overlap_param_pkg::*;
#(
  parameter int SAMPLE_W = 16,
  parameter int CHANNELS = 2
) ();

  localparam int CW = cnt_w(CHANNELS);

  logic [SAMPLE_W-1:0] in_sample;
  logic                in_valid;
  logic                in_ready;
  logic [SAMPLE_W-1:0] out_sample;
  logic [CW-1:0]       out_channel;
  logic                out_first;
  logic                out_last;
  logic                out_valid;
  logic                out_ready;

  modport slave (
    input  in_sample, in_valid, out_ready,
    output in_ready, out_sample, out_channel, out_first, out_last, out_valid
  );

  modport master (
    output in_sample, in_valid, out_ready,
    input  in_ready, out_sample, out_channel, out_first, out_last, out_valid
  );

endinterface

// File: rtl/overlap_param_ram.sv
// rtl/overlap_param_ram.sv - single-port synchronous-read sample store.
module overlap_param_ram #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2304,
  parameter int AW    = 12
) (
  input  logic             clk,
  input  logic             we,
  input  logic             re,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // rdata only moves on re, so a stalled read keeps its word.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/overlap_param.sv
// rtl/overlap_param.sv - overlapping-frame buffer: input fill/refill FSM and emit read pipeline.
// OVERLAP_PARAM_ZERO_PRIME_EN: zero the store after restart and emit the first frame after HOP sets.
module overlap_param
  import overlap_param_pkg::*;
#(
  parameter int SAMPLE_W  = 16,
  parameter int CHANNELS  = 2,
  parameter int FRAME_LEN = 1152,
  parameter int HOP       = 576
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clear,
  overlap_param_if.slave bus
);

  localparam int DEPTH = CHANNELS * FRAME_LEN;
  localparam int AW    = cnt_w(DEPTH);
  localparam int CW    = cnt_w(CHANNELS);
  localparam int IW    = cnt_w(FRAME_LEN);
  localparam logic [CW-1:0] CH_LAST  = CW'(CHANNELS - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(FRAME_LEN - 1);

  if (!params_legal(CHANNELS, FRAME_LEN, HOP)) begin : g_bad_params
    $error("overlap_param: need CHANNELS >= 1 and 1 <= HOP <= FRAME_LEN");
  end

  state_t        state;
  logic [IW-1:0] wp;
  logic [CW-1:0] in_ch;
  logic [IW-1:0] set_cnt;
  logic          in_ready_r;
  logic [IW-1:0] rd_pos;
  logic [IW-1:0] rd_i;
  logic [CW-1:0] rd_ch;
  logic          rd_busy;
  logic          rd_v;
  logic [CW-1:0] rd_ch_q;
  logic          rd_first_q;
  logic          rd_last_q;
  logic          out_valid_r;
  logic [SAMPLE_W-1:0] out_sample_r;
  logic [CW-1:0] out_channel_r;
  logic          out_first_r;
  logic          out_last_r;
  logic [SAMPLE_W-1:0] ram_rdata;

`ifdef OVERLAP_PARAM_ZERO_PRIME_EN
  localparam state_t START_STATE = ST_INIT;
  logic [AW-1:0] init_cnt;
  logic          init_we;
  assign init_we = (state == ST_INIT);
`else
  localparam state_t START_STATE = ST_FILL;
  logic init_we;
  assign init_we = 1'b0;
`endif

  function automatic logic [IW-1:0] inc_wrap(input logic [IW-1:0] v);
    return (v == IDX_LAST) ? '0 : v + 1'b1;
  endfunction

  logic          in_fire, out_fire, advance, rd_issue, set_done;
  logic [IW-1:0] wp_next;
  logic [AW-1:0] in_addr, rd_addr, wr_addr, ram_addr;
  logic          ram_we;

  assign in_fire  = in_ready_r && bus.in_valid;
  assign out_fire = out_valid_r && bus.out_ready;
  assign advance  = !out_valid_r || bus.out_ready;
  assign rd_issue = (state == ST_EMIT) && rd_busy && advance;
  assign set_done = (state == ST_FILL) ? (set_cnt == IDX_LAST) : (set_cnt == IW'(HOP - 1));
  assign wp_next  = inc_wrap(wp);

  assign in_addr  = AW'(int'(in_ch) * FRAME_LEN + int'(wp));
  assign rd_addr  = AW'(int'(rd_ch) * FRAME_LEN + int'(rd_pos));
`ifdef OVERLAP_PARAM_ZERO_PRIME_EN
  assign wr_addr  = init_we ? init_cnt : in_addr;
`else
  assign wr_addr  = in_addr;
`endif
  assign ram_we   = (in_fire || init_we) && !clear;
  assign ram_addr = ram_we ? wr_addr : rd_addr;

  overlap_param_ram #(
    .WIDTH(SAMPLE_W),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .re   (rd_issue),
    .addr (ram_addr),
    .wdata(init_we ? '0 : bus.in_sample),
    .rdata(ram_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= START_STATE;
      wp <= '0; in_ch <= '0; set_cnt <= '0; in_ready_r <= 1'b0;
      rd_pos <= '0; rd_i <= '0; rd_ch <= '0; rd_busy <= 1'b0;
      rd_v <= 1'b0; rd_ch_q <= '0; rd_first_q <= 1'b0; rd_last_q <= 1'b0;
      out_valid_r <= 1'b0; out_sample_r <= '0; out_channel_r <= '0;
      out_first_r <= 1'b0; out_last_r <= 1'b0;
`ifdef OVERLAP_PARAM_ZERO_PRIME_EN
      init_cnt <= '0;
`endif
    end else if (clear) begin
      state <= START_STATE;
      wp <= '0; in_ch <= '0; set_cnt <= '0; in_ready_r <= 1'b0;
      rd_pos <= '0; rd_i <= '0; rd_ch <= '0; rd_busy <= 1'b0;
      rd_v <= 1'b0; rd_ch_q <= '0; rd_first_q <= 1'b0; rd_last_q <= 1'b0;
      out_valid_r <= 1'b0; out_sample_r <= '0; out_channel_r <= '0;
      out_first_r <= 1'b0; out_last_r <= 1'b0;
`ifdef OVERLAP_PARAM_ZERO_PRIME_EN
      init_cnt <= '0;
`endif
    end else begin
      case (state)
`ifdef OVERLAP_PARAM_ZERO_PRIME_EN
        ST_INIT: begin
          init_cnt <= init_cnt + 1'b1;
          if (init_cnt == AW'(DEPTH - 1)) begin
            state      <= ST_REFILL;
            in_ready_r <= 1'b1;
          end
        end
`endif
        ST_FILL, ST_REFILL: begin
          if (!in_fire) begin
            in_ready_r <= 1'b1;
          end else if (in_ch != CH_LAST) begin
            in_ch <= in_ch + 1'b1;
          end else begin
            in_ch <= '0;
            wp    <= wp_next;
            if (set_done) begin
              // wp_next is now the oldest sample, where every channel's read starts.
              state      <= ST_EMIT;
              in_ready_r <= 1'b0;
              set_cnt    <= '0;
              rd_pos     <= wp_next;
              rd_i       <= '0;
              rd_ch      <= '0;
              rd_busy    <= 1'b1;
            end else begin
              set_cnt <= set_cnt + 1'b1;
            end
          end
        end
        ST_EMIT: begin
          if (rd_issue) begin
            if (rd_i == IDX_LAST) begin
              rd_i   <= '0;
              rd_pos <= wp;
              if (rd_ch == CH_LAST) rd_busy <= 1'b0;
              else                  rd_ch   <= rd_ch + 1'b1;
            end else begin
              rd_i   <= rd_i + 1'b1;
              rd_pos <= inc_wrap(rd_pos);
            end
          end
          if (out_fire && out_last_r) begin
            state      <= ST_REFILL;
            in_ready_r <= 1'b1;
          end
        end
        default: state <= START_STATE;
      endcase

      // Two-stage read pipeline (RAM word, then output register) stalls as a unit.
      if (advance) begin
        rd_v        <= rd_issue;
        rd_ch_q     <= rd_ch;
        rd_first_q  <= (rd_ch == '0) && (rd_i == '0);
        rd_last_q   <= (rd_ch == CH_LAST) && (rd_i == IDX_LAST);
        out_valid_r <= rd_v;
        out_first_r <= rd_v && rd_first_q;
        out_last_r  <= rd_v && rd_last_q;
        if (rd_v) begin
          out_sample_r  <= ram_rdata;
          out_channel_r <= rd_ch_q;
        end
      end
    end
  end

  assign bus.in_ready    = in_ready_r;
  assign bus.out_valid   = out_valid_r;
  assign bus.out_sample  = out_sample_r;
  assign bus.out_channel = out_channel_r;
  assign bus.out_first   = out_first_r;
  assign bus.out_last    = out_last_r;

endmodule

// File: tb/tb_overlap_param.sv
// tb/tb_overlap_param.sv - scoreboard bench for overlap_param against a sliding-window model.
// Honours OVERLAP_PARAM_ZERO_PRIME_EN when the bundle is built with it.
module tb_overlap_param;
  import overlap_param_pkg::*;

  localparam int SW = 16;
  localparam int CH = 2;
  localparam int FL = 8;
  localparam int HP = 4;
  localparam int CW = cnt_w(CH);
`ifdef OVERLAP_PARAM_ZERO_PRIME_EN
  localparam bit ZP = 1'b1;
`else
  localparam bit ZP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic clear = 1'b0;
  always #5 clk = ~clk;

  overlap_param_if #(.SAMPLE_W(SW), .CHANNELS(CH)) bus ();

  overlap_param #(
    .SAMPLE_W (SW),
    .CHANNELS (CH),
    .FRAME_LEN(FL),
    .HOP      (HP)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .clear(clear),
    .bus  (bus)
  );

  typedef struct {
    logic [SW-1:0] s;
    int            ch;
    bit            first;
    bit            last;
  } exp_t;

  exp_t          expq[$];
  logic [SW-1:0] win [CH][FL];
  int            mch, sets, need, frames;
  int            checks = 0;
  int            errors = 0;
  int            pops = 0;
  bit            bp_en = 1'b0;
  bit            ready_low = 1'b1;
  bit            stall_prev = 1'b0;
  logic [SW+CW+1:0] held;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for the DUT", name);
  endtask

  // Model: each channel keeps its last FL samples; a frame is due after `need` new sets.
  task automatic model_reset();
    for (int c = 0; c < CH; c++)
      for (int i = 0; i < FL; i++) win[c][i] = '0;
    mch  = 0;
    sets = 0;
    need = ZP ? HP : FL;
    expq.delete();
  endtask

  task automatic model_push(input logic [SW-1:0] v);
    for (int i = 0; i < FL - 1; i++) win[mch][i] = win[mch][i+1];
    win[mch][FL-1] = v;
    if (mch == CH - 1) begin
      mch = 0;
      sets++;
      if (sets == need) begin
        for (int c = 0; c < CH; c++)
          for (int i = 0; i < FL; i++)
            expq.push_back('{win[c][i], c, (c == 0 && i == 0), (c == CH - 1 && i == FL - 1)});
        frames++;
        sets = 0;
        need = HP;
      end
    end else begin
      mch++;
    end
  endtask

  always @(posedge clk) begin
    #2;
    bus.out_ready = ready_low ? 1'b0 : (bp_en ? 1'($urandom_range(1)) : 1'b1);
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    logic [SW+CW+1:0] cur;
    cur = {bus.out_sample, bus.out_channel, bus.out_first, bus.out_last};
    if (!reset || clear) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", bus.out_valid, 1);
        check("stall_hold", cur, held);
      end
      if (bus.out_valid) begin
        check("no_input_during_emit", bus.in_ready, 0);
        if (bus.out_ready) begin
          check("out_expected", expq.size() != 0, 1);
          if (expq.size() != 0) begin
            e = expq.pop_front();
            pops++;
            check("out_sample", bus.out_sample, e.s);
            check("out_channel", bus.out_channel, e.ch);
            check("out_first", bus.out_first, e.first);
            check("out_last", bus.out_last, e.last);
          end
        end
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      held = cur;
    end
  end

  task automatic send(input logic [SW-1:0] v);
    int n = 0;
    bus.in_sample = v;
    bus.in_valid  = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    if (n >= 300) fail("send_timeout");
    else model_push(v);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_until_frame(inout int v, input bit rnd);
    int f0 = frames;
    int k = 0;
    while (frames == f0 && k < 4 * CH * FL) begin
      if (rnd) send(SW'($urandom));
      else begin
        send(SW'(v));
        v++;
      end
      k++;
    end
    if (frames == f0) fail("frame_timeout");
  endtask

  task automatic wait_drain();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(expq.size() == 0 && bus.in_ready) && n < 1000);
    if (n >= 1000) fail("drain_timeout");
    @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    int ready_at = ZP ? CH * FL : 1;
    reset = 1'b1;
    ready_low = 1'b0;
    model_reset();
    for (int k = 1; k <= ready_at; k++) begin
      @(posedge clk);
      #1;
      check("ready_after_reset", bus.in_ready, k == ready_at);
    end
  endtask

  task automatic do_clear();
    ready_low = 1'b1;
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    ready_low = 1'b0;
    model_reset();
  endtask

  task automatic do_reset();
    ready_low = 1'b1;
    bus.in_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("async_rst_in_ready", bus.in_ready, 0);
    check("async_rst_out_valid", bus.out_valid, 0);
    repeat (2) @(posedge clk);
    #1;
    release_reset();
  endtask

  initial begin
    int v, n, p0;
    bus.in_sample = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    frames = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_first", bus.out_first, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_out_sample", bus.out_sample, 0);
    check("rst_out_channel", bus.out_channel, 0);
    release_reset();

    // First frame with free-running out_ready: latency, length, return to input.
    v = 0;
    send_until_frame(v, 1'b0);
    check("lat_t0_valid", bus.out_valid, 0);
    check("lat_t0_ready", bus.in_ready, 0);
    @(posedge clk); #1;
    check("lat_t1_valid", bus.out_valid, 0);
    @(posedge clk); #1;
    check("lat_t2_valid", bus.out_valid, 1);
    n = 0;
    while (bus.out_valid && n < 4 * CH * FL) begin
      n++;
      @(posedge clk); #1;
    end
    check("emit_len", n, CH * FL);
    check("ready_after_last", bus.in_ready, 1);
    wait_drain();

    send_until_frame(v, 1'b0);
    wait_drain();

    bp_en = 1'b1;
    send_until_frame(v, 1'b0);
    wait_drain();
    bp_en = 1'b0;

    do_clear();
    v = 0;
    repeat (6) begin
      send(SW'(v));
      v++;
    end
    do_clear();
    v = 0;
    send_until_frame(v, 1'b0);
    wait_drain();

    send_until_frame(v, 1'b0);
    p0 = pops;
    n = 0;
    while (pops < p0 + 5 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (pops < p0 + 5) fail("emit_wait_timeout");
    do_clear();
    v = 0;
    send_until_frame(v, 1'b0);
    wait_drain();

    repeat (3) begin
      send(SW'(v));
      v++;
    end
    do_reset();
    v = 0;
    send_until_frame(v, 1'b0);
    wait_drain();

    bp_en = 1'b1;
    repeat (4) send_until_frame(v, 1'b1);
    wait_drain();
    bp_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

endmodule
